// File: rtl/preamble_detector_pkg.sv
// preamble_detector_pkg: shared BLE PHY types and framing constants
package preamble_detector_pkg;
  typedef enum logic [1:0] {PHY_1M = 2'd0, PHY_2M = 2'd1, PHY_CODED = 2'd2} ble_phy_t;
  localparam logic [7:0] BlePreamble1M = 8'hAA;
  localparam logic [15:0] BlePreamble2M = 16'hAAAA;
  localparam int BleHeaderBits = 16;
  localparam int BleCrcBits = 24;
  localparam int BlePduCntW = 12;
endpackage

// File: rtl/preamble_detector_aa_correlator.sv
// aa_correlator: combinational preamble + access-address match over the hunt window (option: PREAMBLE_DETECTOR_TOLERANCE_EN)
import preamble_detector_pkg::*;
module aa_correlator #(
  parameter int AA_MAX_ERRORS = 1
) (
  input  logic [47:0] i_window,
  input  logic [31:0] i_aa,
  input  ble_phy_t    i_phy,
  input  logic [5:0]  i_fill,
  output logic        o_hit
);
  logic [7:0]  w_pre_1m;
  logic [15:0] w_pre_2m;
  logic        w_full;
  logic        w_pre_ok;
  logic        w_aa_ok;
  // preamble alternates so that its first air bit equals the AA LSB; coded PHY never matches
  always_comb begin
    w_pre_1m = i_aa[0] ? ~BlePreamble1M : BlePreamble1M;
    w_pre_2m = i_aa[0] ? ~BlePreamble2M : BlePreamble2M;
    w_full = (i_phy == PHY_1M) ? (i_fill >= 6'd40) : (i_phy == PHY_2M) ? (i_fill >= 6'd48) : 1'b0;
    w_pre_ok = (i_phy == PHY_2M) ? (i_window[15:0] == w_pre_2m) : (i_window[15:8] == w_pre_1m);
  end
`ifdef PREAMBLE_DETECTOR_TOLERANCE_EN
  logic [31:0] w_diff;
  logic [5:0]  w_errs;
  // count AA bit errors; the sum collapses into an adder tree
  always_comb begin
    w_diff = i_window[47:16] ^ i_aa;
    w_errs = '0;
    for (int k = 0; k < 32; k++) w_errs = w_errs + {5'd0, w_diff[k]};
  end
  assign w_aa_ok = int'(w_errs) <= AA_MAX_ERRORS;
`else
  assign w_aa_ok = i_window[47:16] == i_aa;
`endif
  assign o_hit = w_full & w_pre_ok & w_aa_ok;
endmodule

// File: rtl/preamble_detector.sv
// preamble_detector: hunts preamble+access address in a 1-bit stream, then forwards header/payload/CRC with tlast
import preamble_detector_pkg::*;
module preamble_detector #(
  parameter int AA_MAX_ERRORS = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        restart,
  input  ble_phy_t    phy,
  input  logic [31:0] access_address,
  input  logic        input_tdata,
  input  logic        input_tvalid,
  output logic        input_tready,
  output logic        output_tdata,
  output logic        output_tvalid,
  input  logic        output_tready,
  output logic        output_tlast,
  output logic        aa_match
);
  localparam logic [1:0] IDLE = 2'd0, HUNT = 2'd1, HEADER = 2'd2, PAYLOAD = 2'd3;
  logic [1:0]            r_state;
  logic [47:0]           r_sr;
  logic [5:0]            r_fill;
  ble_phy_t              r_phy;
  logic [31:0]           r_aa;
  logic [BlePduCntW-1:0] r_cnt;
  logic [BlePduCntW-1:0] r_total;
  logic [6:0]            r_len;
  logic                  r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_match;
  logic [47:0]           w_sr_next;
  logic [5:0]            w_fill_next;
  logic                  w_fwd;
  logic                  w_acc;
  logic                  w_out_acc;
  logic                  w_hit;
  logic [BlePduCntW-1:0] w_total;
  // handshakes, next window, and frame length (len MSB is the bit arriving now)
  always_comb begin
    w_sr_next = {input_tdata, r_sr[47:1]};
    w_fill_next = (r_fill == 6'd48) ? r_fill : r_fill + 6'd1;
    w_fwd = (r_state == HEADER) | (r_state == PAYLOAD);
    input_tready = (r_state == HUNT) | (w_fwd & (~r_tvalid | output_tready) & ~r_tlast);
    w_acc = input_tvalid & input_tready;
    w_out_acc = r_tvalid & output_tready;
    w_total = BlePduCntW'(BleHeaderBits + BleCrcBits) + {1'b0, input_tdata, r_len, 3'd0};
  end
  aa_correlator #(.AA_MAX_ERRORS(AA_MAX_ERRORS)) u_corr (
    .i_window(w_sr_next),
    .i_aa(r_aa),
    .i_phy(r_phy),
    .i_fill(w_fill_next),
    .o_hit(w_hit)
  );
  // hunt, then forward bits with a one-deep output register; restart overrides everything
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_fill <= '0;
      r_phy <= PHY_1M;
      r_aa <= '0;
      r_cnt <= '0;
      r_total <= '0;
      r_len <= '0;
      r_tdata <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_match <= 1'b0;
    end else if (restart) begin
      r_state <= HUNT;
      r_phy <= phy;
      r_aa <= access_address;
      r_sr <= '0;
      r_fill <= '0;
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (r_state == HUNT && w_acc) begin
        r_sr <= w_sr_next;
        r_fill <= w_fill_next;
        if (w_hit) begin
          r_state <= HEADER;
          r_match <= 1'b1;
          r_cnt <= '0;
        end
      end
      if (w_fwd) begin
        if (w_out_acc) r_tvalid <= 1'b0;
        if (w_out_acc && r_tlast) begin
          r_tlast <= 1'b0;
          r_state <= IDLE;
        end
        if (w_acc) begin
          r_tdata <= input_tdata;
          r_tvalid <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          r_tlast <= (r_state == PAYLOAD) && (r_cnt == r_total - 1'b1);
          if (r_state == HEADER && r_cnt[3] && r_cnt[2:0] != 3'd7) r_len <= {input_tdata, r_len[6:1]};
          if (r_state == HEADER && r_cnt == BlePduCntW'(BleHeaderBits - 1)) begin
            r_total <= w_total;
            r_state <= PAYLOAD;
          end
        end
      end
    end
  end
  assign output_tdata = r_tdata;
  assign output_tvalid = r_tvalid;
  assign output_tlast = r_tlast;
  assign aa_match = r_match;
endmodule

// File: tb/tb_preamble_detector.sv
// tb_preamble_detector: randomized directed bench against a bit-history reference model
import preamble_detector_pkg::*;
module tb_preamble_detector;
`ifdef PREAMBLE_DETECTOR_TOLERANCE_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif
  logic aclk = 1'b0, areset = 1'b1, restart = 1'b0;
  ble_phy_t phy = PHY_1M;
  logic [31:0] access_address = '0;
  logic input_tdata = 1'b0, input_tvalid = 1'b0, input_tready;
  logic output_tdata, output_tvalid, output_tready = 1'b1, output_tlast, aa_match;
  int vectors = 0, miscompares = 0;
  logic hist[$];
  logic hbits[$];
  logic body[$];
  ble_phy_t m_phy = PHY_1M;
  logic [31:0] m_aa = '0;
  int hit;

  preamble_detector #(.AA_MAX_ERRORS(1)) dut (
    .aclk(aclk), .areset(areset), .restart(restart), .phy(phy), .access_address(access_address),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
    .output_tlast(output_tlast), .aa_match(aa_match)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // the last W received bits must read preamble then AA in air order
  function automatic logic model_match();
    int w, errs, n;
    logic [15:0] pre;
    if (m_phy == PHY_1M) w = 40;
    else if (m_phy == PHY_2M) w = 48;
    else return 1'b0;
    n = hist.size();
    if (n < w) return 1'b0;
    pre = m_aa[0] ? 16'h5555 : 16'hAAAA;
    for (int i = 0; i < w - 32; i++) if (hist[n - w + i] !== pre[i]) return 1'b0;
    errs = 0;
    for (int j = 0; j < 32; j++) if (hist[n - 32 + j] !== m_aa[j]) errs++;
    return errs <= TOL;
  endfunction

  task automatic build_sync(input logic [31:0] aa, input int pw, input logic [15:0] pre, input logic [31:0] flip);
    for (int i = 0; i < pw; i++) hbits.push_back(pre[i]);
    for (int j = 0; j < 32; j++) hbits.push_back(aa[j] ^ flip[j]);
  endtask

  task automatic build_body(input int len, input logic [7:0] h0);
    logic [7:0] b;
    body.delete();
    b = 8'(len);
    for (int i = 0; i < 8; i++) body.push_back(h0[i]);
    for (int i = 0; i < 8; i++) body.push_back(b[i]);
    for (int i = 0; i < 8 * len + 24 + 6; i++) body.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic do_restart(input ble_phy_t p, input logic [31:0] a);
    restart = 1'b1; phy = p; access_address = a; input_tvalid = 1'b0; output_tready = 1'b1;
    @(posedge aclk); #1;
    restart = 1'b0;
    hist.delete(); m_phy = p; m_aa = a;
    chk("restart_tvalid", output_tvalid, 0);
    chk("restart_tready", input_tready, 1);
    chk("restart_match", aa_match, 0);
  endtask

  task automatic hunt(output int hit_at);
    logic em;
    hit_at = -1;
    for (int i = 0; i < hbits.size(); i++) begin
      input_tvalid = 1'b1; input_tdata = hbits[i]; output_tready = 1'b1;
      #1;
      chk("hunt_tready", input_tready, 1);
      hist.push_back(hbits[i]);
      @(posedge aclk); #1;
      em = model_match();
      chk("aa_match", aa_match, em);
      if (em) begin
        hit_at = i;
        input_tvalid = 1'b0;
        return;
      end
    end
    input_tvalid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
  task automatic forward(input int mode, input int stop_after);
    int n, len, idx, cyc, nbad, nlast, lpos;
    logic got[$];
    logic lastq[$];
    logic rdy, vin, acc, stalled, pd;
    len = 0;
    for (int i = 0; i < 8; i++) len += int'(body[8 + i]) << i;
    n = 16 + 8 * len + 24;
    idx = 0; cyc = 0; stalled = 1'b0; pd = 1'b0;
    while (got.size() < n && cyc < 8 * n + 50) begin
      if (stop_after > 0 && cyc == stop_after) return;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      vin = idx < body.size();
      input_tvalid = vin; input_tdata = vin ? body[idx] : 1'b0; output_tready = rdy;
      #1;
      if (stalled) begin
        chk("stall_valid", output_tvalid, 1);
        chk("stall_data", output_tdata, pd);
      end
      acc = vin & input_tready;
      if (output_tvalid & rdy) begin
        got.push_back(output_tdata);
        lastq.push_back(output_tlast);
      end
      stalled = output_tvalid & ~rdy;
      pd = output_tdata;
      @(posedge aclk); #1;
      if (cyc == 0) chk("match_pulse_width", aa_match, 0);
      if (acc) idx++;
      cyc++;
    end
    input_tvalid = 1'b0; output_tready = 1'b1;
    chk("bit_count", got.size(), n);
    chk("bits_consumed", idx, n);
    nbad = 0; nlast = 0; lpos = -1;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== body[i]) nbad++;
      if (lastq[i] === 1'b1) begin nlast++; lpos = i; end
    end
    chk("fwd_bits_bad", nbad, 0);
    chk("tlast_count", nlast, 1);
    chk("tlast_pos", lpos, n - 1);
    chk("end_tvalid", output_tvalid, 0);
    input_tvalid = 1'b1; #1;
    chk("end_idle_tready", input_tready, 0);
    input_tvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] aa;
    logic [31:0] f2;
    int a, b;
    // reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", input_tready, 0);
    chk("rst_tvalid", output_tvalid, 0);
    chk("rst_tdata", output_tdata, 0);
    chk("rst_tlast", output_tlast, 0);
    chk("rst_match", aa_match, 0);
    areset = 1'b0;
    input_tvalid = 1'b1; input_tdata = 1'b1; #1;
    chk("idle_tready", input_tready, 0);
    @(posedge aclk); #1;
    chk("idle_tvalid", output_tvalid, 0);
    input_tvalid = 1'b0;

    // 1M known frame, header 0x0600
    do_restart(PHY_1M, 32'h8E89BED6);
    hbits.delete(); build_sync(32'h8E89BED6, 8, 16'h00AA, 32'h0);
    hunt(hit);
    chk("1m_hit_idx", hit, 39);
    build_body(6, 8'h00);
    forward(0, 0);

    // 2M correct preamble, random readiness
    do_restart(PHY_2M, 32'h71764129);
    hbits.delete(); build_sync(32'h71764129, 16, 16'h5555, 32'h0);
    hunt(hit);
    chk("2m_hit_idx", hit, 47);
    build_body(3, 8'($urandom));
    forward(2, 0);

    // 2M wrong-polarity preamble
    do_restart(PHY_2M, 32'h71764129);
    hbits.delete(); build_sync(32'h71764129, 16, 16'hAAAA, 32'h0);
    hunt(hit);
    chk("2m_badpre_hit", hit, -1);
    #1;
    chk("2m_badpre_hunt", input_tready, 1);

    // noise then frame, backpressure 1-0-0-1
    aa = $urandom;
    do_restart(PHY_1M, aa);
    hbits.delete();
    for (int i = 0; i < 60; i++) hbits.push_back(1'($urandom_range(0, 1)));
    build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    chk("noise_hit_idx", hit, 99);
    build_body($urandom_range(1, 5), 8'($urandom));
    forward(1, 0);

    // len = 0 gives 40 bits
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    chk("len0_hit_idx", hit, 39);
    build_body(0, 8'h00);
    forward(0, 0);

    // one and two AA bit errors
    a = $urandom_range(0, 31);
    b = (a + 1 + $urandom_range(0, 29)) % 32;
    f2 = (32'h1 << a) | (32'h1 << b);
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h1 << a);
    hunt(hit);
    chk("flip1_hit", hit, TOL >= 1 ? 39 : -1);
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, f2);
    hunt(hit);
    chk("flip2_hit", hit, -1);

    // coded PHY never matches
    do_restart(PHY_CODED, aa);
    hbits.delete();
    build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    build_sync(aa, 16, aa[0] ? 16'h5555 : 16'hAAAA, 32'h0);
    hunt(hit);
    chk("coded_hit", hit, -1);

    // restart mid-payload, then a new frame
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    chk("mid_hit_idx", hit, 39);
    build_body(10, 8'($urandom));
    forward(0, 30);
    chk("mid_tvalid_before", output_tvalid, 1);
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    chk("after_restart_hit", hit, 39);
    build_body(2, 8'($urandom));
    forward(0, 0);

    // async reset mid-header
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    build_body(4, 8'hFF);
    forward(0, 5);
    #2 areset = 1'b1;
    #1;
    chk("arst_tvalid", output_tvalid, 0);
    chk("arst_tdata", output_tdata, 0);
    chk("arst_tlast", output_tlast, 0);
    chk("arst_match", aa_match, 0);
    chk("arst_tready", input_tready, 0);
    #2 areset = 1'b0;
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) begin
      input_tvalid = 1'b1; input_tdata = 1'b1; output_tready = 1'b1; #1;
      chk("post_rst_tready", input_tready, 0);
      @(posedge aclk); #1;
      chk("post_rst_tvalid", output_tvalid, 0);
    end
    input_tvalid = 1'b0;
    do_restart(PHY_1M, aa);
    hbits.delete(); build_sync(aa, 8, aa[0] ? 16'h0055 : 16'h00AA, 32'h0);
    hunt(hit);
    chk("recover_hit", hit, 39);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/preamble_detector.md
# preamble_detector

Receive-side counterpart of the TX preamble/access-address framing for uncoded BLE PHYs. Hunts a demodulated 1-bit AXI-stream for the PHY-specific preamble followed by the configured 32-bit access address. On a match it forwards header, payload and CRC bits downstream and asserts `output_tlast` on the final CRC bit, using the length field from the PDU header. Sits between the GFSK demodulator/bit slicer and the RX dewhitening/CRC chain.

## Interface
- `AA_MAX_ERRORS`, default 1: maximum access-address bit mismatches accepted. Used only with the tolerance macro.
- `aclk` in 1: clock.
- `areset` in 1: asynchronous, active-high reset.
- `restart` in 1: single-cycle pulse that starts a new hunt.
- `phy` in `ble_phy_t`: PHY selection, latched on `restart`.
- `access_address` in 32: expected AA, latched on `restart`.
- `input_tdata` in 1, `input_tvalid` in 1, `input_tready` out 1: demodulated bits, LSB first in air order.
- `output_tdata` out 1, `output_tvalid` out 1, `output_tready` in 1, `output_tlast` out 1: header+payload+CRC bits.
- `aa_match` out 1: one-cycle pulse on detection.

## Operation
- States:
  - IDLE: `input_tready`=0, nothing accepted.
  - HUNT: `input_tready`=1 (never stalls the demodulator).
  - HEADER, PAYLOAD: forwarding.
- `restart` in any state:
  - Latches `phy_q` and `aa_q`.
  - Clears the 48-bit shift register and fill counter.
  - Drops any pending output (`output_tvalid`←0).
  - Goes to HUNT. `restart` has priority over every other event in the same cycle.
- HUNT:
  - Each accepted bit enters the shift register at bit 47 and the register shifts right.
  - The fill counter saturates at 48.
  - Window length W is 40 for PHY_1M and 48 for PHY_2M.
  - PHY_CODED or any other value: bits are consumed but no match is ever declared.
- Match, evaluated on the register contents including the bit just accepted, when fill ≥ W:
  - `sr[47:16] == aa_q`.
  - Preamble field equals `aa_q[0] ? 0x55 : 0xAA` (1M, `sr[15:8]`) or `aa_q[0] ? 0x5555 : 0xAAAA` (2M, `sr[15:0]`). The earliest-received preamble bit therefore equals the AA LSB.
  - The preamble must match exactly.
  - On a match: go to HEADER, pulse `aa_match`, load bit counter = 0.
- HEADER/PAYLOAD:
  - `input_tready = ~output_tvalid | output_tready`, combinational.
  - Each accepted bit is registered to `output_tdata` with `output_tvalid`=1 on the next cycle.
  - Header bits are also captured; `len = header[15:8]`.
  - On acceptance of header bit 16: total = 16 + 8·len + 24, computed in 12 bits (max 2080), state → PAYLOAD.
  - The bit with counter == total−1 is emitted with `output_tlast`=1.
  - When that bit is accepted downstream: `output_tvalid`←0 and state → IDLE.
  - `output_tvalid` stays 1 while `output_tready`=0; data is stable until accepted.

## Timing
- Reset values:
  - state IDLE.
  - `input_tready` 0, `output_tdata` 0, `output_tvalid` 0, `output_tlast` 0, `aa_match` 0.
  - Shift register 0, fill counter 0, `phy_q` PHY_1M, `aa_q` 0.
- Detection latency: last AA bit accepted in cycle N → `aa_match`=1 and state HEADER in cycle N+1.
- Forwarding latency: one cycle input-to-output. Full throughput of one bit per cycle when `output_tready`=1.
- Reset asserted mid-packet aborts immediately; no `output_tlast` is produced.
- `restart` mid-packet discards the in-flight output bit.
- len=0 gives 40 output bits.

## Configuration
- `PREAMBLE_DETECTOR_TOLERANCE_EN` defined:
  - AA comparison uses popcount(`sr[47:16]` ^ `aa_q`) ≤ `AA_MAX_ERRORS`.
  - Popcount is a combinational adder tree; the match is still evaluated in the acceptance cycle.
- Undefined: exact AA compare; `AA_MAX_ERRORS` is ignored.
- The preamble check is exact in both builds.

## Structure
- `ble_phy_t` comes from the shared `ble_types.svh` package.
- Add to the package:
  - Preamble patterns for 1M (8'hAA) and 2M (16'hAAAA).
  - `BleHeaderBits`=16 and `BleCrcBits`=24.
  - Max PDU bit-count width (12).
- One sub-module: `aa_correlator`. It takes the window, `aa_q`, `phy_q` and fill count and produces the combinational match flag. This is where the tolerance macro is applied.

## Test plan
- 1M, AA 0x8E89BED6 (LSB 0): restart, send preamble 0xAA (LSB first), AA, header 0x0600, 6 payload bytes, 3 CRC bytes, `output_tready`=1 → `aa_match` one cycle after AA bit 32; 88 output bits; `output_tlast` only on bit 88; return to IDLE.
- 2M, AA 0x71764129 (LSB 1): preamble 0x5555 → match. Same stream with preamble 0xAAAA → no `aa_match`, stays HUNT.
- Random noise bits then valid frame, 1M: no false match on noise; match exactly on the frame. One AA bit flipped → no match in a default build; match with `PREAMBLE_DETECTOR_TOLERANCE_EN` and `AA_MAX_ERRORS`=1. Two flips → no match in either build.
- Backpressure: `output_tready` toggling 1-0-0-1 during PAYLOAD → `output_tdata` stable while stalled; no bit lost or duplicated; bit count still 16+8·len+24.
- PHY_CODED selected → no match on any input. `restart` asserted mid-PAYLOAD → `output_tvalid`=0 next cycle, state HUNT, new frame detected.
- `areset` pulsed mid-HEADER → all outputs 0 asynchronously, state IDLE, `input_tready`=0 until `restart`.
